// File: rtl/mdu_sequencer.sv
// ---------------------------------------------------------------------------
// mdu_sequencer
//
// Multi-cycle unsigned multiply/divide sequencer for the MIPS datapath.
// Implements MULTU (shift-add) and DIVU (restoring division) and produces
// the HI/LO register values. All adds and subtracts are delegated to an
// external 32-bit ALU through the alu_* port group; this block only
// sequences, shifts and selects.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   start, funct  request pulse (sampled in IDLE), 0 = MULTU, 1 = DIVU
//   src_a, src_b  multiplicand/dividend, multiplier/divisor
//   busy, done    busy while iterating, one-cycle done pulse
//   hi, lo        product high/low or remainder/quotient
//   div_by_zero   sticky flag for DIVU with src_b = 0
//   alu_a, alu_b, alu_binvert, alu_carryin, alu_op   ALU request
//   alu_result, alu_carryout                         ALU response
//
// Optional build macro:
//   MDU_EARLY_OUT_EN  DIVU with src_a < src_b finishes without iterating.
// ---------------------------------------------------------------------------
module mdu_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             funct,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_binvert,
    output logic             alu_carryin,
    output logic [1:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carryout
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_opnd;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_dbz;

    logic [WIDTH-1:0] w_sh;
    logic             w_top;
    logic             w_lastIter;
    logic             w_early;

    // Restoring-division shift: the bit pushed out of hi is kept as w_top so
    // a remainder that overflowed WIDTH bits still forces a subtract.
    assign w_sh       = {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};
    assign w_top      = r_hi[WIDTH-1];
    assign w_lastIter = (r_cnt == CNT_W'(WIDTH - 1));

`ifdef MDU_EARLY_OUT_EN
    // Quotient is zero whenever the dividend is below the divisor.
    assign w_early = (src_a < src_b);
`else
    assign w_early = 1'b0;
`endif

    assign hi          = r_hi;
    assign lo          = r_lo;
    assign busy        = r_busy;
    assign done        = r_done;
    assign div_by_zero = r_dbz;

    // ALU request is decoded from registered state only. MUL adds the
    // multiplicand when the current multiplier bit is set; DIV computes
    // sh - divisor as sh + ~divisor + 1. Idle states request the zero op.
    always_comb begin
        alu_a       = '0;
        alu_b       = '0;
        alu_binvert = 1'b0;
        alu_carryin = 1'b0;
        alu_op      = 2'b11;
        case (r_state)
            S_MUL: begin
                alu_a  = r_hi;
                alu_b  = r_lo[0] ? r_opnd : '0;
                alu_op = 2'b10;
            end
            S_DIV: begin
                alu_a       = w_sh;
                alu_b       = r_opnd;
                alu_binvert = 1'b1;
                alu_carryin = 1'b1;
                alu_op      = 2'b10;
            end
            default: ;
        endcase
    end

    // Sequencer. done is registered from the DONE state, so the pulse
    // appears one cycle after DONE is entered; busy covers exactly the
    // iterating states.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_hi    <= '0;
            r_lo    <= '0;
            r_opnd  <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dbz   <= 1'b0;
        end else begin
            r_done <= (r_state == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_dbz <= 1'b0;
                        r_cnt <= '0;
                        if (!funct) begin
                            r_opnd  <= src_a;
                            r_lo    <= src_b;
                            r_hi    <= '0;
                            r_busy  <= 1'b1;
                            r_state <= S_MUL;
                        end else if (src_b == '0) begin
                            r_hi    <= src_a;
                            r_lo    <= '1;
                            r_dbz   <= 1'b1;
                            r_state <= S_DONE;
                        end else if (w_early) begin
                            r_hi    <= src_a;
                            r_lo    <= '0;
                            r_state <= S_DONE;
                        end else begin
                            r_opnd  <= src_b;
                            r_lo    <= src_a;
                            r_hi    <= '0;
                            r_busy  <= 1'b1;
                            r_state <= S_DIV;
                        end
                    end
                end
                S_MUL: begin
                    // Product shifts right; the ALU carry becomes the new MSB.
                    {r_hi, r_lo} <= {alu_carryout, alu_result, r_lo[WIDTH-1:1]};
                    r_cnt        <= r_cnt + CNT_W'(1);
                    if (w_lastIter) begin
                        r_busy  <= 1'b0;
                        r_state <= S_DONE;
                    end
                end
                S_DIV: begin
                    if (w_top | alu_carryout) begin
                        r_hi <= alu_result;
                        r_lo <= {r_lo[WIDTH-2:0], 1'b1};
                    end else begin
                        r_hi <= w_sh;
                        r_lo <= {r_lo[WIDTH-2:0], 1'b0};
                    end
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_lastIter) begin
                        r_busy  <= 1'b0;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
